// File: rtl/obstacle_engine_if.sv
// Handshake/bus bundle between the game controller and the obstacle engine.
// master drives frame timing, start and jump height; slave returns game state and obstacles.
interface obstacle_engine_if #(
  parameter int NUM_OBS = 3,
  parameter int X_W     = 10
);
  logic                     frame_tick;
  logic                     start;
  logic [5:0]               dinosaur_height;
  logic                     game_status;
  logic                     game_over;
  logic [3:0]               speed;
  logic [NUM_OBS*X_W-1:0]   obs_x;
  logic [NUM_OBS-1:0]       obs_valid;
  logic [15:0]              score;
  logic                     hit;

  modport master (
    output frame_tick, start, dinosaur_height,
    input  game_status, game_over, speed, obs_x, obs_valid, score, hit
  );

  modport slave (
    input  frame_tick, start, dinosaur_height,
    output game_status, game_over, speed, obs_x, obs_valid, score, hit
  );
endinterface

// File: rtl/obstacle_engine.sv
// Dinosaur-runner obstacle engine: IDLE/RUN/OVER game FSM, obstacle scroll and spawn, score, collision.
// All outputs registered; tick effects and hit appear one CLK after the edge that samples them.
module obstacle_engine #(
  parameter int NUM_OBS    = 3,
  parameter int X_W        = 10,
  parameter int SCREEN_W   = 640,
  parameter int OBS_W      = 16,
  parameter int OBS_H      = 20,
  parameter int DINO_X     = 64,
  parameter int DINO_W     = 20,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 15,
  parameter int SPEED_STEP = 256,
  parameter int MIN_GAP    = 160
) (
  input logic             CLK,
  input logic             RST,
  obstacle_engine_if.slave bus
);
  localparam int GAP_W = X_W + 1;
  localparam int SS_W  = $clog2(SPEED_STEP + 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  state_t state, state_nxt;

  logic [NUM_OBS-1:0][X_W-1:0] x_q, x_nxt;
  logic [NUM_OBS-1:0]          valid_q, valid_nxt;
  logic [GAP_W-1:0]            gap_q, gap_nxt;
  logic [SS_W-1:0]             ss_cnt;
  logic [3:0]                  speed_q;
  logic [15:0]                 score_q;
  logic [15:0]                 lfsr;
  logic                        hit_q;
  logic                        collide, do_start, do_tick, spawn_done;
  logic [X_W-1:0]              spd_x;
  logic [GAP_W-1:0]            spd_g;

  assign spd_x = X_W'(speed_q);
  assign spd_g = GAP_W'(speed_q);

  // Overlap test runs at X_W+1 bits so x near the top of the range cannot wrap.
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (valid_q[i] &&
          ({1'b0, x_q[i]} + GAP_W'(OBS_W) > GAP_W'(DINO_X)) &&
          ({1'b0, x_q[i]} < GAP_W'(DINO_X + DINO_W)) &&
          ({1'b0, bus.dinosaur_height} < 7'(OBS_H)))
        collide = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_tick   = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (bus.start) begin
          state_nxt = RUN;
          do_start  = 1'b1;
        end
      end
      RUN: begin
        if (collide) state_nxt = OVER;
        else         do_tick   = bus.frame_tick;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-tick move/retire, then spawn into the lowest channel free after retirement.
  always_comb begin
    x_nxt      = x_q;
    valid_nxt  = valid_q;
    spawn_done = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (valid_q[i]) begin
        if (x_q[i] <= spd_x) valid_nxt[i] = 1'b0;
        else                 x_nxt[i]     = x_q[i] - spd_x;
      end
    end
    gap_nxt = (gap_q > spd_g) ? gap_q - spd_g : '0;
    if (gap_nxt == '0) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (!spawn_done && !valid_nxt[i]) begin
          spawn_done   = 1'b1;
          valid_nxt[i] = 1'b1;
          x_nxt[i]     = X_W'(SCREEN_W - 1);
          gap_nxt      = GAP_W'(MIN_GAP) + GAP_W'(lfsr[7:0]);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q     <= '0;
      valid_q <= '0;
      gap_q   <= '0;
      ss_cnt  <= '0;
      speed_q <= 4'(SPEED_INIT);
      score_q <= '0;
      hit_q   <= 1'b0;
      lfsr    <= 16'hACE1;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      hit_q <= (state == RUN) && collide;
      if (do_start) begin
        valid_q <= '0;
        score_q <= '0;
        gap_q   <= '0;
        ss_cnt  <= '0;
        speed_q <= 4'(SPEED_INIT);
      end else if (do_tick) begin
        x_q     <= x_nxt;
        valid_q <= valid_nxt;
        gap_q   <= gap_nxt;
        if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
        if (ss_cnt == SS_W'(SPEED_STEP - 1)) begin
          ss_cnt <= '0;
          if (speed_q < 4'(SPEED_MAX)) speed_q <= speed_q + 4'd1;
        end else begin
          ss_cnt <= ss_cnt + SS_W'(1);
        end
      end
    end
  end

  assign bus.game_status = (state == RUN);
  assign bus.game_over   = (state == OVER);
  assign bus.speed       = speed_q;
  assign bus.obs_x       = x_q;
  assign bus.obs_valid   = valid_q;
  assign bus.score       = score_q;
  assign bus.hit         = hit_q;
endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench for obstacle_engine: a default instance plus a single-channel, zero-min-gap instance
// sharing the same stimulus.
module tb_obstacle_engine;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  obstacle_engine_if #(.NUM_OBS(3), .X_W(10)) bus ();
  obstacle_engine_if #(.NUM_OBS(1), .X_W(10)) bus1 ();

  obstacle_engine dut (.CLK(CLK), .RST(RST), .bus(bus));
  obstacle_engine #(.NUM_OBS(1), .MIN_GAP(0)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  assign bus1.frame_tick      = bus.frame_tick;
  assign bus1.start           = bus.start;
  assign bus1.dinosaur_height = bus.dinosaur_height;

  int checks   = 0;
  int failures = 0;

  typedef struct { int tick; int spd; } ramp_t;
  ramp_t ramp [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    @(negedge CLK);
    bus.frame_tick = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int ex, sp, r, retire_t;
    bit alive;
    ramp[0] = '{1, 2};    ramp[1] = '{255, 2};  ramp[2] = '{256, 3};  ramp[3] = '{511, 3};
    ramp[4] = '{512, 4};  ramp[5] = '{3327, 14}; ramp[6] = '{3328, 15}; ramp[7] = '{3400, 15};

    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.dinosaur_height = 6'd63;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    chk("rst_status", bus.game_status, 0);
    chk("rst_over", bus.game_over, 0);
    chk("rst_valid", bus.obs_valid, 0);
    chk("rst_x", bus.obs_x, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_speed", bus.speed, 2);
    chk("rst_hit", bus.hit, 0);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_status", bus.game_status, 0);
      chk("idle_valid", bus.obs_valid, 0);
      chk("idle_score", bus.score, 0);
      chk("idle_speed", bus.speed, 2);
    end

    bus.start = 1'b1;
    @(negedge CLK);
    chk("start_status", bus.game_status, 1);
    chk("start_score", bus.score, 0);

    // Long run: ch0 scroll/retire, single-channel deferral, score count and speed ramp.
    ex = 0; sp = 2; r = 0; alive = 1'b0; retire_t = 0;
    for (int t = 1; t <= 3400; t++) begin
      if (t == 5) bus.start = 1'b0;
      tick();
      if (t == 1) begin
        ex = 639; alive = 1'b1;
      end else if (alive) begin
        if (ex <= sp) begin alive = 1'b0; retire_t = t; end
        else ex = ex - sp;
      end
      sp = (2 + t / 256 > 15) ? 15 : 2 + t / 256;

      chk("run_score", bus.score, t);
      chk("run_status", bus.game_status, 1);
      if (alive) begin
        chk("ch0_x", bus.obs_x[9:0], ex);
        chk("ch0_valid", bus.obs_valid[0], 1);
        chk("solo_x", bus1.obs_x[9:0], ex);
        chk("solo_valid", bus1.obs_valid[0], 1);
      end else if (t == retire_t) begin
        chk("ch0_retire", int'(!bus.obs_valid[0] || bus.obs_x[9:0] == 10'd639), 1);
        chk("solo_respawn_x", bus1.obs_x[9:0], 639);
        chk("solo_respawn_valid", bus1.obs_valid[0], 1);
      end
      if (r < 8 && t == ramp[r].tick) begin
        chk("ramp_speed", bus.speed, ramp[r].spd);
        r++;
      end
    end
    chk("retire_seen", retire_t, 299);

    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    for (int t = 0; t < 276; t++) tick();
    chk("col_pre_x", bus.obs_x[9:0], 69);
    chk("col_pre_speed", bus.speed, 3);

    bus.dinosaur_height = 6'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("clear_hit", bus.hit, 0);
      chk("clear_status", bus.game_status, 1);
    end

    bus.dinosaur_height = 6'd5;
    bus.frame_tick = 1'b1;
    @(negedge CLK);
    bus.frame_tick = 1'b0;
    chk("col_hit", bus.hit, 1);
    chk("col_over", bus.game_over, 1);
    chk("col_status", bus.game_status, 0);
    chk("col_x_frozen", bus.obs_x[9:0], 69);
    chk("col_score_frozen", bus.score, 276);
    @(negedge CLK);
    chk("col_hit_once", bus.hit, 0);
    chk("col_over_hold", bus.game_over, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("over_hit", bus.hit, 0);
      chk("over_score", bus.score, 276);
      chk("over_x", bus.obs_x[9:0], 69);
      chk("over_speed", bus.speed, 3);
    end

    bus.dinosaur_height = 6'd63;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    chk("restart_status", bus.game_status, 1);
    chk("restart_over", bus.game_over, 0);
    chk("restart_score", bus.score, 0);
    chk("restart_speed", bus.speed, 2);
    chk("restart_valid", bus.obs_valid, 0);

    for (int i = 0; i < 3; i++) tick();
    chk("pre_arst_score", bus.score, 3);
    #2 RST = 1'b1;
    #1;
    chk("arst_status", bus.game_status, 0);
    chk("arst_score", bus.score, 0);
    chk("arst_speed", bus.speed, 2);
    chk("arst_valid", bus.obs_valid, 0);
    chk("arst_x", bus.obs_x, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_arst_idle", bus.game_status, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
